// File: rtl/mem_pkg.sv
// Shared definitions for the cache-to-memory line bus responder.
// Holds the line geometry constants and the responder FSM state type.
package mem_pkg;

   localparam int unsigned LINE_BYTES       = 32;
   localparam int unsigned LINE_OFFSET_BITS = 5;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StWait = 2'd1,
      StAck  = 2'd2,
      StDone = 2'd3
   } mem_state_e;

endpackage

// File: rtl/mem_array.sv
// Line storage: 2^DEPTH_LOG2 lines, synchronous write, asynchronous read.
// Kept as a plain array so synthesis can map it to RAM or a vendor macro can replace it.
module mem_array
   import mem_pkg::*;
#(
   parameter int unsigned LINE_WIDTH = LINE_BYTES * 8,
   parameter int unsigned DEPTH_LOG2 = 10
) (
   input  logic                  clk,
   input  logic                  i_we,
   input  logic [DEPTH_LOG2-1:0] i_addr,
   input  logic [LINE_WIDTH-1:0] i_wdata,
   output logic [LINE_WIDTH-1:0] o_rdata
);

   logic [LINE_WIDTH-1:0] r_mem [2**DEPTH_LOG2];

   // No reset: contents survive a responder reset.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the cache line bus: latch, wait LATENCY, ack, then drive or store.
// Define MEMRESP_ERR_EN to enable the sticky protocol checker on err.
module mem_responder
   import mem_pkg::*;
#(
   parameter int unsigned LINE_WIDTH = 256,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DEPTH_LOG2 = 10,
   parameter int unsigned LATENCY    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] maddr,
   input  logic                  mreq,
   input  logic                  mwrite,
   output logic                  ack_n,
   inout  wire  [LINE_WIDTH-1:0] mdata,
   output logic                  err
);

   localparam int unsigned IdxLo = LINE_OFFSET_BITS;
   localparam int unsigned IdxHi = DEPTH_LOG2 + LINE_OFFSET_BITS - 1;
   localparam int unsigned CntW  = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
   localparam logic [CntW-1:0] CntLoad = (LATENCY >= 2) ? CntW'(LATENCY - 2) : '0;

   mem_state_e            r_state, w_state_nxt;
   logic [CntW-1:0]       r_cnt, w_cnt_nxt;
   logic [DEPTH_LOG2-1:0] r_index;
   logic                  r_write;
   logic                  w_accept;
   logic                  w_drive;
   logic                  w_we;
   logic [LINE_WIDTH-1:0] w_rdata;
   logic                  w_unused_addr;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_accept    = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (mreq) begin
               w_accept = 1'b1;
               if (LATENCY == 1) begin
                  w_state_nxt = StAck;
               end else begin
                  w_state_nxt = StWait;
                  w_cnt_nxt   = CntLoad;
               end
            end
         end
         StWait: begin
            // A dropped request abandons the access with no ack, write or bus drive.
            if (!mreq) begin
               w_state_nxt = StIdle;
               w_cnt_nxt   = '0;
            end else if (r_cnt == '0) begin
               w_state_nxt = StAck;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         StAck: begin
            w_state_nxt = StDone;
         end
         StDone: begin
            if (!mreq) begin
               w_state_nxt = StIdle;
            end
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= StIdle;
         r_cnt   <= '0;
         r_index <= '0;
         r_write <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_accept) begin
            r_index <= maddr[IdxHi:IdxLo];
            r_write <= mwrite;
         end
      end
   end

   assign ack_n   = (r_state != StAck);
   assign w_drive = (r_state == StAck) && !r_write;
   assign w_we    = (r_state == StAck) && r_write;
   assign mdata   = w_drive ? w_rdata : {LINE_WIDTH{1'bz}};

   mem_array #(
      .LINE_WIDTH (LINE_WIDTH),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_mem_array (
      .clk     (clk),
      .i_we    (w_we),
      .i_addr  (r_index),
      .i_wdata (mdata),
      .o_rdata (w_rdata)
   );

`ifdef MEMRESP_ERR_EN
   logic [ADDR_WIDTH-IdxLo-1:0] r_tag;
   logic                        r_err;
   logic                        w_abort;
   logic                        w_changed;

   assign w_abort   = (r_state == StWait) && !mreq;
   assign w_changed = ((r_state == StWait) || (r_state == StAck)) &&
                      ((maddr[ADDR_WIDTH-1:IdxLo] != r_tag) || (mwrite != r_write));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tag <= '0;
         r_err <= 1'b0;
      end else begin
         if (w_accept) begin
            r_tag <= maddr[ADDR_WIDTH-1:IdxLo];
         end
         if (w_abort || w_changed) begin
            r_err <= 1'b1;
         end
      end
   end

   assign err           = r_err;
   assign w_unused_addr = ^maddr[IdxLo-1:0];

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (rst && w_abort) begin
         $display("%m: request dropped while waiting at %0t", $time);
      end
      if (rst && w_changed) begin
         $display("%m: address or direction changed mid-transaction at %0t", $time);
      end
   end
`endif
`else
   assign err           = 1'b0;
   assign w_unused_addr = ^{maddr[IdxLo-1:0], maddr[ADDR_WIDTH-1:IdxHi+1]};
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a LATENCY=4 instance and a LATENCY=1 instance.
module tb_mem_responder;

   localparam int unsigned LW = 256;

   localparam logic [LW-1:0] P1 = {8{32'hDEAD_BEEF}};
   localparam logic [LW-1:0] P2 = {4{64'h0123_4567_89AB_CDEF}};
   localparam logic [LW-1:0] P3 = {8{32'hA5A5_5A5A}};
   localparam logic [LW-1:0] P4 = {8{32'hFFFF_0000}};
   localparam logic [LW-1:0] P5 = {8{32'h1357_9BDF}};
   localparam logic [LW-1:0] P6 = {2{128'hCAFE_F00D_0BAD_C0DE_FEED_FACE_8BAD_F00D}};

`ifdef MEMRESP_ERR_EN
   localparam logic ErrExp = 1'b1;
`else
   localparam logic ErrExp = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [31:0]   maddr = '0, maddr1 = '0;
   logic          mreq = 1'b0, mreq1 = 1'b0;
   logic          mwrite = 1'b0, mwrite1 = 1'b0;
   logic          ack_n, ack1_n, err, err1;
   logic [LW-1:0] drv = '0, drv1 = '0;
   logic          oe = 1'b0, oe1 = 1'b0;
   wire  [LW-1:0] mdata, mdata1;

   int n_checks = 0;
   int n_errors = 0;

   assign mdata  = oe  ? drv  : {LW{1'bz}};
   assign mdata1 = oe1 ? drv1 : {LW{1'bz}};

   always #5 clk = ~clk;

   mem_responder #(
      .LINE_WIDTH (256),
      .ADDR_WIDTH (32),
      .DEPTH_LOG2 (10),
      .LATENCY    (4)
   ) u_dut (
      .clk    (clk),
      .rst    (rst),
      .maddr  (maddr),
      .mreq   (mreq),
      .mwrite (mwrite),
      .ack_n  (ack_n),
      .mdata  (mdata),
      .err    (err)
   );

   mem_responder #(
      .LINE_WIDTH (256),
      .ADDR_WIDTH (32),
      .DEPTH_LOG2 (10),
      .LATENCY    (1)
   ) u_dut1 (
      .clk    (clk),
      .rst    (rst),
      .maddr  (maddr1),
      .mreq   (mreq1),
      .mwrite (mwrite1),
      .ack_n  (ack1_n),
      .mdata  (mdata1),
      .err    (err1)
   );

   task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // A released bus reads as Z on a 4-state simulator and as 0 on a 2-state one.
   task automatic check_rel(input string tag, input logic [LW-1:0] bus);
      n_checks++;
      assert ((bus === {LW{1'bz}}) || (bus === '0)) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected high-Z", tag, bus);
      end
   endtask

   // One LATENCY=4 transaction starting at a negedge; mreq held 'hold' extra cycles in DONE.
   task automatic req4(input string tag, input logic [31:0] addr, input logic wr,
                       input logic [LW-1:0] data, input int hold);
      maddr  = addr;
      mwrite = wr;
      mreq   = 1'b1;
      oe     = wr;
      drv    = data;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         check1({tag, " wait ack_n"}, ack_n, 1'b1);
         if (!wr) check_rel({tag, " wait bus"}, mdata);
      end
      @(negedge clk);
      check1({tag, " ack_n"}, ack_n, 1'b0);
      if (!wr) check({tag, " rdata"}, mdata, data);
      for (int i = 0; i <= hold; i++) begin
         @(negedge clk);
         check1({tag, " done ack_n"}, ack_n, 1'b1);
         if (!wr) check_rel({tag, " done bus"}, mdata);
      end
      mreq = 1'b0;
      oe   = 1'b0;
      @(negedge clk);
      check1({tag, " idle ack_n"}, ack_n, 1'b1);
      check_rel({tag, " idle bus"}, mdata);
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check1("rst ack_n", ack_n, 1'b1);
      check1("rst err", err, 1'b0);
      check_rel("rst bus", mdata);
      check1("rst ack1_n", ack1_n, 1'b1);
      check1("rst err1", err1, 1'b0);
      check_rel("rst bus1", mdata1);
      rst = 1'b1;
      @(negedge clk);

      // Write then read, offset and wrap aliasing
      req4("wr40", 32'h0000_0040, 1'b1, P1, 0);
      req4("rd40", 32'h0000_0040, 1'b0, P1, 0);
      req4("wr20", 32'h0000_0020, 1'b1, P2, 0);
      req4("rd803F", 32'h0000_803F, 1'b0, P2, 0);
      req4("wr00", 32'h0000_0000, 1'b1, P3, 0);
      req4("rd801F", 32'h0000_801F, 1'b0, P3, 0);

      // Held request after ack: single pulse, then normal latency again
      req4("hold", 32'h0000_0040, 1'b0, P1, 3);
      req4("after hold", 32'h0000_0020, 1'b0, P2, 0);

      // Abort a write in its second WAIT cycle
      maddr  = 32'h0000_0040;
      mwrite = 1'b1;
      mreq   = 1'b1;
      oe     = 1'b1;
      drv    = P4;
      @(negedge clk);
      check1("abort w1 ack_n", ack_n, 1'b1);
      @(negedge clk);
      check1("abort w2 ack_n", ack_n, 1'b1);
      mreq = 1'b0;
      oe   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check1("abort no ack", ack_n, 1'b1);
      end
      check1("abort err", err, ErrExp);
      req4("abort rd40", 32'h0000_0040, 1'b0, P1, 0);

      // Reset pulse during WAIT of a write
      maddr  = 32'h0000_0020;
      mwrite = 1'b1;
      mreq   = 1'b1;
      oe     = 1'b1;
      drv    = P5;
      @(negedge clk);
      check1("rstw w1 ack_n", ack_n, 1'b1);
      @(negedge clk);
      rst  = 1'b0;
      mreq = 1'b0;
      oe   = 1'b0;
      #1;
      check1("rstw ack_n", ack_n, 1'b1);
      check_rel("rstw bus", mdata);
      check1("rstw err", err, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      req4("rstw rd20", 32'h0000_0020, 1'b0, P2, 0);

      // LATENCY=1: write acked at k+1, read after one-cycle gap acked at k+4
      maddr1  = 32'h0000_0060;
      mwrite1 = 1'b1;
      mreq1   = 1'b1;
      oe1     = 1'b1;
      drv1    = P6;
      @(negedge clk);
      check1("l1 wr ack1_n", ack1_n, 1'b0);
      @(negedge clk);
      check1("l1 done ack1_n", ack1_n, 1'b1);
      mreq1 = 1'b0;
      oe1   = 1'b0;
      @(negedge clk);
      check1("l1 gap ack1_n", ack1_n, 1'b1);
      check_rel("l1 gap bus", mdata1);
      mwrite1 = 1'b0;
      mreq1   = 1'b1;
      @(negedge clk);
      check1("l1 rd ack1_n", ack1_n, 1'b0);
      check("l1 rdata", mdata1, P6);
      @(negedge clk);
      check1("l1 rd done ack1_n", ack1_n, 1'b1);
      check_rel("l1 rd done bus", mdata1);
      mreq1 = 1'b0;
      @(negedge clk);
      check1("l1 idle ack1_n", ack1_n, 1'b1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
